uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte FIFO sitting directly upstream of `uart_tx`, between the memory-mapped UART register write port and the transmitter's read handshake. It absorbs bursts of CPU writes and hands bytes to the transmitter one at a time, each as a single-cycle valid pulse. It also reports fill level, full/empty, and a sticky overflow flag for the UART status register.

## Interface
- `DEPTH`, default 16: entry count; power of two, ≥ 2.
- `LEVEL_W`, default $clog2(DEPTH)+1: width of the level output, derived and not overridden.
- `clk_i` input, 1: sole clock, rising edge.
- `reset_ni` input, 1: one clock; reset is asynchronous and active-low.
- `write_data_i` input, 8: byte to enqueue.
- `write_enable_i` input, 1: enqueue request, one byte per cycle high.
- `flush_i` input, 1: synchronous discard of all contents.
- `clear_overflow_i` input, 1: clears the sticky overflow flag.
- `read_enable_i` input, 1: level from `uart_tx` meaning "transmitter idle, wants a byte".
- `read_data_o` output, 8: byte presented to `uart_tx`.
- `read_valid_o` output, 1: one-cycle pulse qualifying `read_data_o`.
- `full_o` output, 1: level == DEPTH.
- `empty_o` output, 1: level == 0.
- `level_o` output, LEVEL_W: current entry count, 0..DEPTH.
- `overflow_o` output, 1: sticky flag, set when a write was dropped.

## Operation
- **Storage:** circular buffer of DEPTH×8 bits.
  - Write and read pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2·DEPTH.
  - level = wr_ptr − rd_ptr, computed in LEVEL_W bits and registered.
- **Push:** when `write_enable_i` && !`full_o` (value at start of cycle).
  - Stores `write_data_i` at wr_ptr[addr] and increments wr_ptr.
- **Dropped write:** when `write_enable_i` && `full_o`.
  - The byte is discarded and `overflow_o` is set.
  - This applies even if a pop happens in the same cycle; there is no same-cycle space reuse.
- **Pop condition:** `read_enable_i` && !`empty_o` && !`read_valid_o`.
  - On pop: `read_data_o` <= mem[rd_ptr[addr]], `read_valid_o` <= 1, rd_ptr increments.
  - The `read_valid_o` term is mandatory. `uart_tx` keeps `read_enable_i` high during the cycle the pulse is presented, because its shift register loads only at that edge. Without this term a second byte would be popped and lost.
- **Idle read side:** `read_valid_o` <= 0 on every cycle without a pop. `read_data_o` holds its last value.
- **No bypass:** a push into an empty FIFO is not poppable in the same cycle.
- **Simultaneous push and pop:** level unchanged, both pointers advance.
- **Flush (`flush_i`):**
  - Sets both pointers to 0 and forces `read_valid_o` <= 0.
  - Takes priority over any push or pop in the same cycle; that push is dropped silently, and `overflow_o` is not set by it.
  - Does not clear `overflow_o`.
- **Overflow flag:**
  - `clear_overflow_i` clears `overflow_o`.
  - If a set event and `clear_overflow_i` occur in the same cycle, set wins.
- **Reset (asserted at any time, including mid-burst):**
  - Pointers = 0.
  - `read_valid_o` = 0, `read_data_o` = 8'h00, `overflow_o` = 0, `level_o` = 0.
  - `empty_o` = 1, `full_o` = 0.
  - Memory contents are don't-care.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Push at edge N: `level_o`, `empty_o`, `full_o` update at N+1.
  - Earliest `read_valid_o` pulse is at N+2, provided `read_enable_i` is high in cycle N+1.
- Pop decision in cycle M: `read_valid_o` is high for exactly cycle M+1, and level drops at M+1.
  - The next pop can be decided no earlier than cycle M+2. Maximum drain rate is one byte per two cycles; `uart_tx` needs far fewer.
- Write throughput: one byte per cycle until full.
- Reset deassertion: first push is accepted on the first rising edge after `reset_ni` goes high.

## Test plan
- **Reset:** assert `reset_ni` low mid-burst with level 5 -> immediately `empty_o`=1, `level_o`=0, `read_valid_o`=0, `overflow_o`=0. After release, write 8'hA5 -> `read_data_o`=8'hA5 appears with a single `read_valid_o` pulse.
- **Ordering and wrap:** write 8'h00..8'h27 (40 bytes, DEPTH=16) paced against a model `uart_tx` -> bytes emerge in order, each with exactly one valid pulse, and pointers wrap with no loss.
- **Full boundary:**
  - Write 16 bytes -> `full_o`=1, `level_o`=16.
  - Write a 17th with a pop in the same cycle -> the 17th is dropped, `overflow_o`=1, `level_o`=15.
  - Assert `clear_overflow_i` -> `overflow_o`=0.
- **Double-pop guard:** hold `read_enable_i` high continuously with 3 bytes queued -> pulses occur on alternate cycles, 3 pulses total, and `level_o` steps 3,2,1,0 with no skipped byte.
- **Empty with simultaneous events:** with the FIFO empty and `read_enable_i`=1, write 8'h3C -> no pulse that cycle, pulse with 8'h3C exactly two edges after the write.
- **Flush priority:** level 6, assert `flush_i` together with `write_enable_i` and `read_enable_i` -> next cycle `level_o`=0, `read_valid_o`=0, `overflow_o` unchanged.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the UART register write port, the TX FIFO and uart_tx.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface uart_tx_fifo_if #(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
);
  logic [7:0]         write_data_i;
  logic               write_enable_i;
  logic               flush_i;
  logic               clear_overflow_i;
  logic               read_enable_i;
  logic [7:0]         read_data_o;
  logic               read_valid_o;
  logic               full_o;
  logic               empty_o;
  logic [LEVEL_W-1:0] level_o;
  logic               overflow_o;

  modport slave (
    input  write_data_i, write_enable_i, flush_i, clear_overflow_i, read_enable_i,
    output read_data_o, read_valid_o, full_o, empty_o, level_o, overflow_o
  );

  modport master (
    output write_data_i, write_enable_i, flush_i, clear_overflow_i, read_enable_i,
    input  read_data_o, read_valid_o, full_o, empty_o, level_o, overflow_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: absorbs CPU write bursts, hands bytes out as single-cycle
// valid pulses, and reports level/full/empty plus a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int LEVEL_W = AW + 1;

  logic [7:0]         mem_q [DEPTH];
  logic [LEVEL_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               full_q, full_d, empty_q, empty_d;
  logic               ovf_q, ovf_d;
  logic               push, pop, drop;

  always_comb begin
    // Full/empty are the registered start-of-cycle view: a pop never frees room for a
    // same-cycle push, and a same-cycle push is never poppable.
    push = bus.write_enable_i && !full_q && !bus.flush_i;
    drop = bus.write_enable_i &&  full_q && !bus.flush_i;
    // rvalid_q term stops a second pop while uart_tx still holds read_enable_i high.
    pop  = bus.read_enable_i && !empty_q && !rvalid_q && !bus.flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + LEVEL_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + LEVEL_W'(1);
    end

    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (level_d == LEVEL_W'(DEPTH));
    empty_d  = (level_d == '0);
    rvalid_d = pop;
    rdata_d  = pop ? mem_q[rd_ptr_q[AW-1:0]] : rdata_q;

    ovf_d = ovf_q;
    if (drop)                      ovf_d = 1'b1;
    else if (bus.clear_overflow_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only readable behind a valid pointer pair.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.write_data_i;
  end

  assign bus.read_data_o  = rdata_q;
  assign bus.read_valid_o = rvalid_q;
  assign bus.full_o       = full_q;
  assign bus.empty_o      = empty_q;
  assign bus.level_o      = level_q;
  assign bus.overflow_o   = ovf_q;
endmodule
